// File: rtl/uart_rx_manch_if.sv
// Ready/valid handshake carrying received words from uart_rx_manch to its consumer.
interface uart_rx_manch_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_manch.sv
// Manchester-coded UART receiver: two samples per bit, coding/stop checks, ready/valid output.
// Optional MANCH_RESYNC_EN: realign sampling on each mid-bit transition of the data bits.
module uart_rx_manch #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int BAUDRATE  = 115200,
  parameter int CLK_FREQ  = 18_750_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  uart_rx_manch_if.master bus,
  output logic            busy,
  output logic            err_manch,
  output logic            err_frame,
  output logic            err_overrun
);
  localparam int FULLBAUD = CLK_FREQ / BAUDRATE;
  localparam int HALFBAUD = FULLBAUD / 2;
  localparam int QUARTER  = HALFBAUD / 2;

  typedef enum logic [2:0] {IDLE_S, START_S, DATA_S, STOP_S, DONE_S} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic                 rs;
  logic                 rs_d_reg;
  logic [31:0]          cnt_reg, cnt_next;
  logic [31:0]          lim;
  logic                 sample;
  logic                 half_reg, half_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic                 a_reg, a_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 manch_flag_reg, manch_flag_next;
  logic                 stop_flag_reg, stop_flag_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 err_manch_reg, err_manch_next;
  logic                 err_frame_reg, err_frame_next;
  logic                 err_overrun_reg, err_overrun_next;
`ifdef MANCH_RESYNC_EN
  logic                 resynced_reg, resynced_next;
`endif

  assign rs = sync_reg[1];

  // The first start sample sits a quarter bit in; every later one is a half bit apart.
  assign lim    = (state_reg == START_S && !half_reg) ? 32'(QUARTER - 1) : 32'(HALFBAUD - 1);
  assign sample = (cnt_reg == lim);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg        <= 2'b11;
      rs_d_reg        <= 1'b1;
      state_reg       <= IDLE_S;
      cnt_reg         <= '0;
      half_reg        <= 1'b0;
      bit_cnt_reg     <= '0;
      a_reg           <= 1'b0;
      shift_reg       <= '0;
      manch_flag_reg  <= 1'b0;
      stop_flag_reg   <= 1'b0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      err_manch_reg   <= 1'b0;
      err_frame_reg   <= 1'b0;
      err_overrun_reg <= 1'b0;
`ifdef MANCH_RESYNC_EN
      resynced_reg    <= 1'b0;
`endif
    end else begin
      sync_reg        <= {sync_reg[0], rx};
      rs_d_reg        <= rs;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      half_reg        <= half_next;
      bit_cnt_reg     <= bit_cnt_next;
      a_reg           <= a_next;
      shift_reg       <= shift_next;
      manch_flag_reg  <= manch_flag_next;
      stop_flag_reg   <= stop_flag_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      err_manch_reg   <= err_manch_next;
      err_frame_reg   <= err_frame_next;
      err_overrun_reg <= err_overrun_next;
`ifdef MANCH_RESYNC_EN
      resynced_reg    <= resynced_next;
`endif
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg + 32'd1;
    half_next        = half_reg;
    bit_cnt_next     = bit_cnt_reg;
    a_next           = a_reg;
    shift_next       = shift_reg;
    manch_flag_next  = manch_flag_reg;
    stop_flag_next   = stop_flag_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = rx_valid_reg;
    err_manch_next   = 1'b0;
    err_frame_next   = 1'b0;
    err_overrun_next = 1'b0;
`ifdef MANCH_RESYNC_EN
    resynced_next    = resynced_reg;
`endif

    if (rx_valid_reg && bus.rx_ready) rx_valid_next = 1'b0;

    case (state_reg)
      IDLE_S: begin
        cnt_next     = '0;
        half_next    = 1'b0;
        bit_cnt_next = '0;
        if (rs_d_reg && !rs) state_next = START_S;
      end
      START_S: begin
        if (sample) begin
          cnt_next = '0;
          if (!half_reg) begin
            // A line that is high again at the first centre was only a glitch.
            if (rs) state_next = IDLE_S;
            else    half_next  = 1'b1;
          end else if (!rs) begin
            state_next     = IDLE_S;
            err_frame_next = 1'b1;
          end else begin
            state_next   = DATA_S;
            half_next    = 1'b0;
            bit_cnt_next = '0;
          end
        end
      end
      DATA_S: begin
        if (sample) begin
          cnt_next = '0;
          if (!half_reg) begin
            a_next    = rs;
            half_next = 1'b1;
`ifdef MANCH_RESYNC_EN
            resynced_next = 1'b0;
`endif
          end else begin
            half_next  = 1'b0;
            shift_next = {a_reg, shift_reg[DATA_BITS-1:1]};
            if (a_reg == rs) manch_flag_next = 1'b1;
            if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
              state_next   = STOP_S;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
`ifdef MANCH_RESYNC_EN
        // Mid-bit transition near where it is expected: put sample b a quarter bit past it.
        else if (half_reg && !resynced_reg && (rs != rs_d_reg) && cnt_reg <= 32'(2 * QUARTER)) begin
          cnt_next      = 32'(HALFBAUD - QUARTER);
          resynced_next = 1'b1;
        end
`endif
      end
      STOP_S: begin
        if (sample) begin
          cnt_next = '0;
          if (!rs) stop_flag_next = 1'b1;
          if (bit_cnt_reg == 4'(2 * STOP_BITS - 1)) begin
            state_next   = DONE_S;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      DONE_S: begin
        state_next = IDLE_S;
        if (stop_flag_reg) begin
          err_frame_next = 1'b1;
        end else if (rx_valid_reg && !bus.rx_ready) begin
          err_overrun_next = 1'b1;
        end else begin
          // Loading here overrides a same-cycle accept, so valid stays up with the new word.
          rx_data_next  = shift_reg;
          rx_valid_next = 1'b1;
        end
        if (manch_flag_reg) err_manch_next = 1'b1;
        manch_flag_next = 1'b0;
        stop_flag_next  = 1'b0;
      end
      default: state_next = IDLE_S;
    endcase
  end

  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign busy         = (state_reg != IDLE_S);
  assign err_manch    = err_manch_reg;
  assign err_frame    = err_frame_reg;
  assign err_overrun  = err_overrun_reg;
endmodule
